// File: rtl/hamming_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hamming_pkg                                                                |
// | Shared Hamming(7,4) constants, source tag type and correction helper.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package hamming_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    // Row j produces syndrome bit j, so the syndrome reads as the 1-based error position.
    localparam logic [SYN_W-1:0][CW_W-1:0] H_MATRIX = {7'b1111000, 7'b1100110, 7'b1010101};

    // Codeword bit feeding each data bit, MSB first: {cw[6], cw[5], cw[4], cw[2]}.
    localparam logic [DATA_W-1:0][2:0] DATA_POS = {3'd6, 3'd5, 3'd4, 3'd2};

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    function automatic logic [CW_W-1:0] flip_mask(input logic [SYN_W-1:0] syn);
        flip_mask = '0;
        for (int i = 0; i < CW_W; i++) begin
            if (syn == SYN_W'(i + 1)) begin
                flip_mask[i] = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_rx_sched_syndrome_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | syndrome_calc                                                              |
// | Combinational mod-2 product of the parity-check matrix and a codeword.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module syndrome_calc
    import hamming_pkg::*;
#(
    parameter logic [SYN_W-1:0][CW_W-1:0] H = H_MATRIX
) (
    input  logic [CW_W-1:0]  cw,
    output logic [SYN_W-1:0] syn
);

    generate
        for (genvar j = 0; j < SYN_W; j++) begin : g_row
            assign syn[j] = ^(H[j] & cw);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/hamming_rx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hamming_rx_sched                                                           |
// | Two-requester round-robin front end feeding a shared two-stage Hamming(7,4)|
// | correction pipeline with a saturating corrected-word counter.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hamming_rx_sched
    import hamming_pkg::*;
#(
    parameter int                          CNT_W = 16,
    parameter logic [SYN_W-1:0][CW_W-1:0]  H     = H_MATRIX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [CW_W-1:0]   a_cw,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [CW_W-1:0]   b_cw,
    output logic              b_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic [SYN_W-1:0]  out_syn,
    output logic              out_corr,
    output logic [CNT_W-1:0]  err_count
);

    src_t              r_last;
    logic              r_s1_valid;
    logic [CW_W-1:0]   r_s1_cw;
    src_t              r_s1_src;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_s1_ready;
    logic              w_s2_ready;
    logic              w_acc_a;
    logic              w_acc_b;
    logic              w_load_s2;
    logic [SYN_W-1:0]  w_syn;
    logic [CW_W-1:0]   w_fixed;
    logic [DATA_W-1:0] w_data;

    // On a tie the requester that did not win last time gets the slot.
    assign w_grant_b  = b_valid & (~a_valid | (r_last == SRC_A));
    assign w_grant_a  = a_valid & ~w_grant_b;

    assign w_s2_ready = ~out_valid | out_ready;
    assign w_s1_ready = ~r_s1_valid | w_s2_ready;

    assign a_ready    = w_grant_a & w_s1_ready;
    assign b_ready    = w_grant_b & w_s1_ready;
    assign w_acc_a    = a_valid & a_ready;
    assign w_acc_b    = b_valid & b_ready;
    assign w_load_s2  = r_s1_valid & w_s2_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last     <= SRC_B;
            r_s1_valid <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_src   <= SRC_A;
        end else begin
            if (w_acc_a) begin
                r_last <= SRC_A;
            end else if (w_acc_b) begin
                r_last <= SRC_B;
            end
            if (w_s1_ready) begin
                r_s1_valid <= w_acc_a | w_acc_b;
                if (w_acc_b) begin
                    r_s1_cw  <= b_cw;
                    r_s1_src <= SRC_B;
                end else if (w_acc_a) begin
                    r_s1_cw  <= a_cw;
                    r_s1_src <= SRC_A;
                end
            end
        end
    end

    syndrome_calc #(
        .H   (H)
    ) u_syndrome_calc (
        .cw  (r_s1_cw),
        .syn (w_syn)
    );

    assign w_fixed = r_s1_cw ^ flip_mask(w_syn);

    generate
        for (genvar k = 0; k < DATA_W; k++) begin : g_data
            assign w_data[k] = w_fixed[DATA_POS[k]];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            out_syn   <= '0;
            out_corr  <= 1'b0;
            err_count <= '0;
        end else begin
            if (w_s2_ready) begin
                out_valid <= r_s1_valid;
            end
            if (w_load_s2) begin
                out_data <= w_data;
                out_src  <= r_s1_src;
                out_syn  <= w_syn;
                out_corr <= |w_syn;
            end
            // Count on the consumer handshake so a stalled word is counted once.
            if (out_valid & out_ready & out_corr & ~&err_count) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hamming_rx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hamming_rx_sched                                                        |
// | Randomized bench with a nearest-codeword reference decoder.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_hamming_rx_sched;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_valid = 1'b0;
    logic [6:0]       a_cw = '0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [6:0]       b_cw = '0;
    logic             b_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_data;
    logic             out_src;
    logic [2:0]       out_syn;
    logic             out_corr;
    logic [CNT_W-1:0] err_count;

    always #5 clk = ~clk;

    hamming_rx_sched #(
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_cw      (a_cw),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_cw      (b_cw),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_syn   (out_syn),
        .out_corr  (out_corr),
        .err_count (err_count)
    );

    // Accepted words as {src, cw}; outputs as {data, src, syn, corr}.
    logic [7:0] acc_q[$];
    int         acc_cyc[$];
    logic [8:0] got_q[$];
    int         got_cyc[$];
    logic [6:0] a_pend[$];
    logic [6:0] b_pend[$];
    int         a_gap = 0;
    int         b_gap = 0;
    int         rdy_pct = 100;
    bit         rdy_auto = 1'b0;
    int         cyc = 0;
    int         nvec = 0;
    int         nfail = 0;
    int         model_err = 0;

    // Textbook Hamming(7,4): data at positions 3,5,6,7, parity at 1,2,4.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [7:1] p;
        p[3] = d[0];
        p[5] = d[1];
        p[6] = d[2];
        p[7] = d[3];
        p[1] = p[3] ^ p[5] ^ p[7];
        p[2] = p[3] ^ p[6] ^ p[7];
        p[4] = p[5] ^ p[6] ^ p[7];
        return p;
    endfunction

    // Perfect code: every 7-bit word lies within distance 1 of exactly one codeword.
    function automatic logic [6:0] decode(input logic [6:0] cw);
        logic [6:0] diff;
        decode = '0;
        for (int d = 0; d < 16; d++) begin
            diff = encode(4'(d)) ^ cw;
            if (diff == 7'd0) begin
                decode = {4'(d), 3'd0};
            end else if ($countones(diff) == 1) begin
                for (int b = 0; b < 7; b++) begin
                    if (diff[b]) decode = {4'(d), 3'(b + 1)};
                end
            end
        end
    endfunction

    function automatic logic [8:0] model_w(input logic [7:0] acc);
        logic [6:0] r;
        r = decode(acc[6:0]);
        return {r[6:3], acc[7], r[2:0], r[2:0] != 3'd0};
    endfunction

    function automatic logic [6:0] err_word(input logic [3:0] d, input int e);
        logic [6:0] w;
        w = encode(d);
        if (e != 0) w[e-1] = ~w[e-1];
        return w;
    endfunction

    task automatic clear_q();
        acc_q.delete();
        acc_cyc.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic drive(input bit a_acc, input bit b_acc);
        if (a_acc) void'(a_pend.pop_front());
        if (b_acc) void'(b_pend.pop_front());
        if (!a_valid || a_acc) begin
            a_valid = (a_pend.size() > 0) && (int'($urandom_range(99)) >= a_gap);
            if (a_valid) a_cw = a_pend[0];
            else a_cw = 7'($urandom);
        end
        if (!b_valid || b_acc) begin
            b_valid = (b_pend.size() > 0) && (int'($urandom_range(99)) >= b_gap);
            if (b_valid) b_cw = b_pend[0];
            else b_cw = 7'($urandom);
        end
        if (rdy_auto) out_ready = int'($urandom_range(99)) < rdy_pct;
    endtask

    task automatic step();
        bit a_acc;
        bit b_acc;
        @(negedge clk);
        a_acc = a_valid && a_ready;
        b_acc = b_valid && b_ready;
        if (a_acc) begin acc_q.push_back({1'b0, a_cw}); acc_cyc.push_back(cyc); end
        if (b_acc) begin acc_q.push_back({1'b1, b_cw}); acc_cyc.push_back(cyc); end
        if (out_valid && out_ready) begin
            got_q.push_back({out_data, out_src, out_syn, out_corr});
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        drive(a_acc, b_acc);
    endtask

    task automatic drain(input int max_cyc, output bit timed_out);
        int n;
        n = 0;
        while ((a_pend.size() > 0 || b_pend.size() > 0 || got_q.size() < acc_q.size())
               && n < max_cyc) begin
            step();
            n++;
        end
        timed_out = (n >= max_cyc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        out_ready = 1'b0;
        a_pend.delete();
        b_pend.delete();
        clear_q();
        model_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++;
        if ({out_valid, out_data, out_src, out_syn, out_corr} !== 10'd0) begin
            nfail++;
            $display("FAIL reset_outputs: got %b, expected 0", {out_valid, out_data, out_src, out_syn, out_corr});
        end
        nvec++;
        if (err_count !== '0) begin
            nfail++;
            $display("FAIL reset_err_count: got %0d, expected 0", err_count);
        end
    endtask

    task automatic test_clean();
        bit to;
        clear_q();
        a_gap = 0; b_gap = 0; rdy_auto = 1'b1; rdy_pct = 100;
        a_pend.push_back(7'h55);
        drive(1'b0, 1'b0);
        drain(20, to);
        nvec++;
        if (to || got_q.size() != 1) begin
            nfail++;
            $display("FAIL clean_count: got %0d outputs (timeout=%0d), expected 1", got_q.size(), to);
        end else begin
            nvec++;
            if (got_q[0] !== 9'b1011_0_000_0) begin
                nfail++;
                $display("FAIL clean_word: got {data,src,syn,corr}=%b, expected 101100000", got_q[0]);
            end
            nvec++;
            if (got_cyc[0] - acc_cyc[0] !== 2) begin
                nfail++;
                $display("FAIL clean_latency: got %0d cycles, expected 2", got_cyc[0] - acc_cyc[0]);
            end
        end
        nvec++;
        if (err_count !== CNT_W'(model_err)) begin
            nfail++;
            $display("FAIL clean_err_count: got %0d, expected %0d", err_count, model_err);
        end
    endtask

    task automatic test_single_err();
        bit to;
        clear_q();
        b_pend.push_back(7'h45);
        drive(1'b0, 1'b0);
        drain(20, to);
        nvec++;
        if (to || got_q.size() != 1) begin
            nfail++;
            $display("FAIL single_count: got %0d outputs (timeout=%0d), expected 1", got_q.size(), to);
        end else begin
            nvec++;
            if (got_q[0] !== 9'b1011_1_101_1) begin
                nfail++;
                $display("FAIL single_word: got {data,src,syn,corr}=%b, expected 101111011", got_q[0]);
            end
        end
        model_err = model_err + 1;
        nvec++;
        if (err_count !== CNT_W'(model_err)) begin
            nfail++;
            $display("FAIL single_err_count: got %0d, expected %0d", err_count, model_err);
        end
    endtask

    task automatic test_contention();
        bit to;
        logic [8:0] exp_w;
        do_reset();
        a_gap = 0; b_gap = 0; rdy_auto = 1'b1; rdy_pct = 100;
        for (int i = 0; i < 10; i++) begin
            a_pend.push_back(7'($urandom));
            b_pend.push_back(7'($urandom));
        end
        drive(1'b0, 1'b0);
        drain(60, to);
        nvec++;
        if (to || got_q.size() != 20 || acc_q.size() != 20) begin
            nfail++;
            $display("FAIL contention_count: got %0d outputs for %0d accepts (timeout=%0d), expected 20", got_q.size(), acc_q.size(), to);
        end
        for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
            exp_w = model_w(acc_q[i]);
            nvec++;
            if (got_q[i] !== exp_w || got_q[i][4] !== i[0] || got_cyc[i] !== got_cyc[0] + i) begin
                nfail++;
                $display("FAIL contention_word[%0d]: got %b at cycle %0d, expected %b src %0d at cycle %0d",
                         i, got_q[i], got_cyc[i], exp_w, i[0], got_cyc[0] + i);
            end
            if (exp_w[0]) model_err = (model_err == CNT_MAX) ? CNT_MAX : model_err + 1;
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [8:0] exp_w;
        logic [9:0] snap;
        clear_q();
        a_gap = 0; b_gap = 0; rdy_auto = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a_pend.push_back(7'($urandom));
            b_pend.push_back(7'($urandom));
        end
        drive(1'b0, 1'b0);
        repeat (5) step();
        snap = {out_valid, out_data, out_src, out_syn, out_corr};
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            nvec++;
            if ({out_valid, out_data, out_src, out_syn, out_corr} !== snap || snap[9] !== 1'b1) begin
                nfail++;
                $display("FAIL stall_hold[%0d]: got %b, expected %b with valid set", k,
                         {out_valid, out_data, out_src, out_syn, out_corr}, snap);
            end
            nvec++;
            if ({a_ready, b_ready} !== 2'b00) begin
                nfail++;
                $display("FAIL stall_ready[%0d]: got %b, expected 00", k, {a_ready, b_ready});
            end
        end
        out_ready = 1'b1;
        drain(100, to);
        nvec++;
        if (to || got_q.size() != 24 || acc_q.size() != 24) begin
            nfail++;
            $display("FAIL stall_count: got %0d outputs for %0d accepts (timeout=%0d), expected 24", got_q.size(), acc_q.size(), to);
        end
        for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
            exp_w = model_w(acc_q[i]);
            nvec++;
            if (got_q[i] !== exp_w || got_q[i][4] !== (got_q[0][4] ^ i[0])) begin
                nfail++;
                $display("FAIL stall_word[%0d]: got %b, expected %b with alternating source", i, got_q[i], exp_w);
            end
            if (exp_w[0]) model_err = (model_err == CNT_MAX) ? CNT_MAX : model_err + 1;
        end
    endtask

    task automatic test_sweep();
        bit to;
        logic [8:0] exp_w;
        logic [8:0] g;
        clear_q();
        a_gap = 20; rdy_auto = 1'b1; rdy_pct = 70;
        for (int c = 0; c < 128; c++) a_pend.push_back(err_word(4'(c >> 3), c & 7));
        drive(1'b0, 1'b0);
        drain(800, to);
        nvec++;
        if (to || got_q.size() != 128) begin
            nfail++;
            $display("FAIL sweep_count: got %0d outputs (timeout=%0d), expected 128", got_q.size(), to);
        end
        for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
            exp_w = model_w(acc_q[i]);
            g = got_q[i];
            nvec++;
            if (g !== exp_w || g[8:5] !== 4'(i >> 3) || g[3:1] !== 3'(i & 7)) begin
                nfail++;
                $display("FAIL sweep_word[%0d]: got %b, expected data %h syn %0d (model %b)", i, g, 4'(i >> 3), i & 7, exp_w);
            end
            if (exp_w[0]) model_err = (model_err == CNT_MAX) ? CNT_MAX : model_err + 1;
        end
        nvec++;
        if (err_count !== CNT_W'(model_err)) begin
            nfail++;
            $display("FAIL sweep_err_count: got %0d, expected %0d", err_count, model_err);
        end
    endtask

    task automatic test_random();
        bit to;
        logic [8:0] exp_w;
        clear_q();
        a_gap = 30; b_gap = 30; rdy_auto = 1'b1; rdy_pct = 60;
        for (int i = 0; i < 60; i++) begin
            a_pend.push_back(7'($urandom));
            b_pend.push_back(7'($urandom));
        end
        drive(1'b0, 1'b0);
        drain(1000, to);
        nvec++;
        if (to || got_q.size() != 120 || acc_q.size() != 120) begin
            nfail++;
            $display("FAIL random_count: got %0d outputs for %0d accepts (timeout=%0d), expected 120", got_q.size(), acc_q.size(), to);
        end
        for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
            exp_w = model_w(acc_q[i]);
            nvec++;
            if (got_q[i] !== exp_w) begin
                nfail++;
                $display("FAIL random_word[%0d]: got %b, expected %b", i, got_q[i], exp_w);
            end
            if (exp_w[0]) model_err = (model_err == CNT_MAX) ? CNT_MAX : model_err + 1;
        end
        nvec++;
        if (err_count !== CNT_W'(model_err)) begin
            nfail++;
            $display("FAIL random_err_count: got %0d, expected %0d", err_count, model_err);
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        a_gap = 0; b_gap = 0; rdy_auto = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_pend.push_back(err_word(4'($urandom), 1 + int'($urandom_range(6))));
            b_pend.push_back(err_word(4'($urandom), 1 + int'($urandom_range(6))));
        end
        drive(1'b0, 1'b0);
        repeat (3) step();
        out_ready = 1'b0;
        step();
        nvec++;
        if (out_valid !== 1'b1 || {a_ready, b_ready} !== 2'b00) begin
            nfail++;
            $display("FAIL rstmid_setup: got valid=%b readys=%b, expected valid=1 readys=00", out_valid, {a_ready, b_ready});
        end
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if (out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL rstmid_valid: got %b, expected 0", out_valid);
        end
        nvec++;
        if (err_count !== '0) begin
            nfail++;
            $display("FAIL rstmid_err_count: got %0d, expected 0", err_count);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_pend.delete();
        b_pend.delete();
        model_err = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        out_ready = 1'b1;
        repeat (8) step();
        nvec++;
        if (got_q.size() !== 0 || out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL rstmid_flush: got %0d outputs valid=%b, expected 0 outputs", got_q.size(), out_valid);
        end
    endtask

    task automatic test_saturation();
        bit to;
        logic [8:0] exp_w;
        do_reset();
        a_gap = 0; b_gap = 0; rdy_auto = 1'b1; rdy_pct = 100;
        for (int i = 0; i < (CNT_MAX + 3) / 2; i++) begin
            a_pend.push_back(err_word(4'($urandom), 1 + int'($urandom_range(6))));
            b_pend.push_back(err_word(4'($urandom), 1 + int'($urandom_range(6))));
        end
        drive(1'b0, 1'b0);
        drain(1000, to);
        nvec++;
        if (to || got_q.size() != CNT_MAX + 3) begin
            nfail++;
            $display("FAIL sat_count: got %0d outputs (timeout=%0d), expected %0d", got_q.size(), to, CNT_MAX + 3);
        end
        for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
            exp_w = model_w(acc_q[i]);
            nvec++;
            if (got_q[i] !== exp_w) begin
                nfail++;
                $display("FAIL sat_word[%0d]: got %b, expected %b", i, got_q[i], exp_w);
            end
            if (exp_w[0]) model_err = (model_err == CNT_MAX) ? CNT_MAX : model_err + 1;
        end
        nvec++;
        if (err_count !== {CNT_W{1'b1}}) begin
            nfail++;
            $display("FAIL sat_err_count: got %0d, expected %0d", err_count, CNT_MAX);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean();
        test_single_err();
        test_contention();
        test_backpressure();
        test_sweep();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
